// File: rtl/mem_pkg.sv
// mem_pkg: funct3 width codes, FSM state type and strobe helper for the memory stage
package mem_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   function automatic logic [3:0] lane_mask(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 4'b0001 : (f3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
   endfunction
endpackage

// File: rtl/mem_bus_if.sv
// mem_bus_if: req/ack data-memory bus between the memory stage and data memory
interface mem_bus_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_align.sv
// mem_align: byte-lane placement of store data, access legality, and load extraction/extension
module mem_align
   import mem_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic        i_store,
   input  logic [31:0] i_rs2,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wstrb,
   output logic        o_fault,
   output logic [31:0] o_ldata
);
   logic        w_illegal;
   logic        w_misalign;
   logic [31:0] w_shift;

   // legality check, store lane replication/strobes, and shifted/extended load data
   always_comb begin
      w_illegal  = i_store ? (i_funct3 > F3_W) : (i_funct3 inside {3'b011, 3'b110, 3'b111});
      w_misalign = (i_funct3[1:0] == 2'b01) ? i_addr_lo[0] :
                   (i_funct3[1:0] == 2'b10) ? (i_addr_lo != 2'b00) : 1'b0;
      o_fault    = w_illegal | w_misalign;
      o_wdata    = (i_funct3[1:0] == 2'b00) ? {4{i_rs2[7:0]}} :
                   (i_funct3[1:0] == 2'b01) ? {2{i_rs2[15:0]}} : i_rs2;
      o_wstrb    = lane_mask(i_funct3) << i_addr_lo;
      w_shift    = i_rdata >> {i_addr_lo, 3'b000};
      o_ldata    = (i_funct3 == F3_B)  ? {{24{w_shift[7]}}, w_shift[7:0]} :
                   (i_funct3 == F3_H)  ? {{16{w_shift[15]}}, w_shift[15:0]} :
                   (i_funct3 == F3_BU) ? {24'h0, w_shift[7:0]} :
                   (i_funct3 == F3_HU) ? {16'h0, w_shift[15:0]} : i_rdata;
   end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage driving a req/ack data bus and registering the MEM/WB payload
module mem_stage
   import mem_pkg::*;
#(
   parameter int TIMEOUT = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        memRead_in,
   input  logic        memWrite_in,
   input  logic        memtoReg_in,
   input  logic        regWrite_in,
   input  logic [31:0] ALUResult_in,
   input  logic [31:0] rs2_in,
   input  logic [31:0] inst_in,
   output logic        stall_out,
   mem_bus_if.master   bus,
   output logic        memtoReg_out,
   output logic        regWrite_out,
   output logic [31:0] ALUResult_out,
   output logic [31:0] readData_out,
   output logic [31:0] inst_out,
   output logic        fault_out
);
   localparam int            CW   = $clog2(TIMEOUT + 2);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

   state_t        r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic          r_to;
   logic          r_req, r_we;
   logic [31:0]   r_addr, r_wdata, r_ldata;
   logic [3:0]    r_wstrb;
   logic [31:0]   w_wdata, w_ldata;
   logic [3:0]    w_wstrb;
   logic          w_afault, w_access, w_load, w_fault;
   logic          w_launch, w_done, w_timeout, w_capture, w_flt;

   assign bus.mem_req   = r_req;
   assign bus.mem_we    = r_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.mem_wstrb = r_wstrb;

   assign w_access  = memRead_in | memWrite_in;
   assign w_load    = memRead_in & ~memWrite_in;
   assign w_fault   = w_access & w_afault;
   assign w_timeout = (r_state == BUSY) && !bus.mem_ack && (TIMEOUT != 0) && (r_cnt == LAST);

   mem_align u_align (
      .i_funct3  (inst_in[14:12]),
      .i_addr_lo (ALUResult_in[1:0]),
      .i_store   (memWrite_in),
      .i_rs2     (rs2_in),
      .i_rdata   (bus.mem_rdata),
      .o_wdata   (w_wdata),
      .o_wstrb   (w_wstrb),
      .o_fault   (w_afault),
      .o_ldata   (w_ldata)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   // FSM next state: launch legal accesses, leave BUSY on ack or timeout, RESP lasts one cycle
   always_comb begin
      w_next = (r_state == IDLE) ? (w_launch ? BUSY : IDLE) :
               (r_state == BUSY) ? ((bus.mem_ack || w_timeout) ? RESP : BUSY) : IDLE;
   end

   // FSM outputs: stall while launching or busy; WB capture in IDLE (non-launch) and RESP
   always_comb begin
      w_launch  = rst && (r_state == IDLE) && w_access && !w_fault;
      w_done    = (r_state == BUSY) && (bus.mem_ack || w_timeout);
      w_capture = ((r_state == IDLE) && !w_launch) || (r_state == RESP);
      w_flt     = (r_state == RESP) ? r_to : w_fault;
      stall_out = w_launch || (r_state == BUSY);
   end

   // BUSY-cycle counter, timeout flag and aligned load data captured on ack
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_to    <= 1'b0;
         r_ldata <= '0;
      end else begin
         r_cnt   <= w_launch ? '0 : (r_state == BUSY) ? r_cnt + 1'b1 : r_cnt;
         r_to    <= w_launch ? 1'b0 : w_timeout ? 1'b1 : r_to;
         r_ldata <= ((r_state == BUSY) && bus.mem_ack) ? w_ldata : r_ldata;
      end
   end

   // bus outputs registered at launch and held stable until the transaction ends
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
      end else begin
         r_req   <= w_launch ? 1'b1 : w_done ? 1'b0 : r_req;
         r_we    <= w_launch ? memWrite_in : r_we;
         r_addr  <= w_launch ? {ALUResult_in[31:2], 2'b00} : r_addr;
         r_wdata <= w_launch ? w_wdata : r_wdata;
         r_wstrb <= w_launch ? (memWrite_in ? w_wstrb : 4'h0) : r_wstrb;
      end
   end

   // MEM/WB payload: real instruction on capture cycles, bubble otherwise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regWrite_out  <= 1'b0;
         memtoReg_out  <= 1'b0;
         fault_out     <= 1'b0;
         ALUResult_out <= '0;
         inst_out      <= '0;
         readData_out  <= '0;
      end else begin
         regWrite_out  <= w_capture & regWrite_in & ~w_flt;
         memtoReg_out  <= w_capture & memtoReg_in & ~w_flt;
         fault_out     <= w_capture & w_flt;
         ALUResult_out <= w_capture ? ALUResult_in : '0;
         inst_out      <= w_capture ? inst_in : '0;
         readData_out  <= ((r_state == RESP) && w_load && !r_to) ? r_ldata : '0;
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven and randomized checks of mem_stage against a behavioural model
module tb_mem_stage;
   localparam int TO = 4;

   typedef struct {
      logic        rd, wr, m2r, rw;
      logic [2:0]  f3;
      logic [31:0] addr, rs2, rdata, inst;
      int          k;
      int          e_busy;
      logic [3:0]  e_wstrb;
      logic [31:0] e_wdata, e_rd;
      logic        e_fault, e_rw, e_m2r;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        memRead_in = 1'b0, memWrite_in = 1'b0, memtoReg_in = 1'b0, regWrite_in = 1'b0;
   logic [31:0] ALUResult_in = '0, rs2_in = '0, inst_in = '0;
   logic        stall_out, memtoReg_out, regWrite_out, fault_out;
   logic [31:0] ALUResult_out, readData_out, inst_out;
   int          checks = 0;
   int          errors = 0;
   vec_t        tab[15];

   mem_bus_if bus ();

   mem_stage #(.TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst           (rst),
      .memRead_in    (memRead_in),
      .memWrite_in   (memWrite_in),
      .memtoReg_in   (memtoReg_in),
      .regWrite_in   (regWrite_in),
      .ALUResult_in  (ALUResult_in),
      .rs2_in        (rs2_in),
      .inst_in       (inst_in),
      .stall_out     (stall_out),
      .bus           (bus),
      .memtoReg_out  (memtoReg_out),
      .regWrite_out  (regWrite_out),
      .ALUResult_out (ALUResult_out),
      .readData_out  (readData_out),
      .inst_out      (inst_out),
      .fault_out     (fault_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rd, wr, m2r, rw, input logic [2:0] f3,
                               input logic [31:0] addr, rs2, rdata, input int k, e_busy,
                               input logic [3:0] e_wstrb, input logic [31:0] e_wdata, e_rd,
                               input logic e_fault);
      vec_t v;
      v.rd = rd; v.wr = wr; v.m2r = m2r; v.rw = rw; v.f3 = f3;
      v.addr = addr; v.rs2 = rs2; v.rdata = rdata; v.k = k;
      v.inst = $urandom;
      v.inst[14:12] = f3;
      v.e_busy = e_busy; v.e_wstrb = e_wstrb; v.e_wdata = e_wdata; v.e_rd = e_rd;
      v.e_fault = e_fault;
      v.e_rw = rw & ~e_fault;
      v.e_m2r = m2r & ~e_fault;
      return v;
   endfunction

   // reference model: derives expectations from access size, alignment and ack timing
   function automatic vec_t model(input vec_t v);
      int          size, off;
      logic        acc, legal, afault, acked;
      logic [31:0] mask, val;
      acc    = v.rd | v.wr;
      size   = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
      legal  = v.wr ? (v.f3 <= 3'd2) : (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      off    = int'(v.addr[1:0]);
      afault = acc && (!legal || (off % size) != 0);
      acked  = v.k >= 1 && v.k <= TO;
      v.e_busy  = (acc && !afault) ? (acked ? v.k : TO) : 0;
      v.e_fault = afault || (v.e_busy != 0 && !acked);
      v.e_rw    = v.rw & ~v.e_fault;
      v.e_m2r   = v.m2r & ~v.e_fault;
      v.e_wstrb = 4'(((1 << size) - 1) << off);
      for (int b = 0; b < 4; b++) v.e_wdata[8*b +: 8] = v.rs2[8*(b % size) +: 8];
      mask = (size == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * size)) - 1);
      val  = (v.rdata >> (8 * off)) & mask;
      if (!v.f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
      v.e_rd = (v.rd && !v.wr && !v.e_fault) ? val : 32'h0;
      return v;
   endfunction

   // applies one instruction starting just after a rising edge with the DUT in IDLE
   task automatic do_instr(input vec_t v);
      int busy;
      memRead_in = v.rd; memWrite_in = v.wr; memtoReg_in = v.m2r; regWrite_in = v.rw;
      ALUResult_in = v.addr; rs2_in = v.rs2; inst_in = v.inst;
      bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
      #1;
      chk("stall_launch", 32'(stall_out), 32'(v.e_busy != 0));
      if (v.e_busy != 0) begin
         @(posedge clk); #1;
         chk("mem_req", 32'(bus.mem_req), 32'h1);
         chk("mem_addr", bus.mem_addr, {v.addr[31:2], 2'b00});
         chk("mem_we", 32'(bus.mem_we), 32'(v.wr));
         if (v.wr) begin
            chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(v.e_wstrb));
            chk("mem_wdata", bus.mem_wdata, v.e_wdata);
         end
         busy = 0;
         while (bus.mem_req === 1'b1 && busy < 40) begin
            busy++;
            chk("stall_busy", 32'(stall_out), 32'h1);
            bus.mem_ack = (busy == v.k);
            bus.mem_rdata = (busy == v.k) ? v.rdata : $urandom;
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            bus.mem_rdata = $urandom;
         end
         chk("busy_cycles", 32'(busy), 32'(v.e_busy));
         chk("stall_resp", 32'(stall_out), 32'h0);
         chk("bubble_rw", 32'(regWrite_out), 32'h0);
      end
      @(posedge clk); #1;
      chk("regWrite_out", 32'(regWrite_out), 32'(v.e_rw));
      chk("memtoReg_out", 32'(memtoReg_out), 32'(v.e_m2r));
      chk("fault_out", 32'(fault_out), 32'(v.e_fault));
      chk("readData_out", readData_out, v.e_rd);
      chk("ALUResult_out", ALUResult_out, v.addr);
      chk("inst_out", inst_out, v.inst);
      chk("req_idle", 32'(bus.mem_req), 32'h0);
   endtask

   task automatic clear_inputs();
      memRead_in = 1'b0; memWrite_in = 1'b0; memtoReg_in = 1'b0; regWrite_in = 1'b0;
      ALUResult_in = '0; rs2_in = '0; inst_in = '0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = '0;
      //          rd wr m2r rw f3      addr          rs2           rdata         k  busy wstrb    wdata         rd            fault
      tab[0]  = mk(0, 0, 0, 1, 3'b000, 32'h0000_1234, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        0);
      tab[1]  = mk(0, 1, 0, 0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,       2, 2, 4'b1000, 32'hA5A5_A5A5, 32'h0,       0);
      tab[2]  = mk(1, 0, 1, 1, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 1, 1, 4'b0000, 32'h0,       32'hFFFF_8001, 0);
      tab[3]  = mk(1, 0, 1, 1, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 3, 3, 4'b0000, 32'h0,       32'h0000_8001, 0);
      tab[4]  = mk(1, 0, 1, 1, 3'b010, 32'h0000_0106, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,        32'h0,        1);
      tab[5]  = mk(1, 0, 1, 1, 3'b010, 32'h0000_0200, 32'h0,        32'hDEAD_BEEF, 0, 4, 4'b0000, 32'h0,       32'h0,        1);
      tab[6]  = mk(1, 0, 1, 1, 3'b010, 32'h0000_0200, 32'h0,        32'hDEAD_BEEF, 4, 4, 4'b0000, 32'h0,       32'hDEAD_BEEF, 0);
      tab[7]  = mk(0, 1, 0, 0, 3'b010, 32'h0000_0020, 32'h1234_5678, 32'h0,       1, 1, 4'b1111, 32'h1234_5678, 32'h0,       0);
      tab[8]  = mk(0, 1, 0, 0, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'h0,       3, 3, 4'b1100, 32'hBEEF_BEEF, 32'h0,       0);
      tab[9]  = mk(0, 1, 0, 0, 3'b011, 32'h0000_0100, 32'h0000_0055, 32'h0,       1, 0, 4'b0000, 32'h0,        32'h0,        1);
      tab[10] = mk(1, 0, 1, 1, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_8000, 1, 1, 4'b0000, 32'h0,       32'hFFFF_FF80, 0);
      tab[11] = mk(1, 0, 1, 1, 3'b100, 32'h0000_0103, 32'h0,        32'hF000_0000, 2, 2, 4'b0000, 32'h0,       32'h0000_00F0, 0);
      tab[12] = mk(1, 1, 1, 1, 3'b000, 32'h0000_0042, 32'h0000_003C, 32'hFFFF_FFFF, 1, 1, 4'b0100, 32'h3C3C_3C3C, 32'h0,       0);
      tab[13] = mk(1, 0, 1, 1, 3'b110, 32'h0000_0100, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,        32'h0,        1);
      tab[14] = mk(0, 1, 0, 0, 3'b001, 32'h0000_0101, 32'h0000_1111, 32'h0,       1, 0, 4'b0000, 32'h0,        32'h0,        1);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", 32'(stall_out), 32'h0);
      chk("rst_req", 32'(bus.mem_req), 32'h0);
      chk("rst_we", 32'(bus.mem_we), 32'h0);
      chk("rst_wstrb", 32'(bus.mem_wstrb), 32'h0);
      chk("rst_addr", bus.mem_addr, 32'h0);
      chk("rst_wdata", bus.mem_wdata, 32'h0);
      chk("rst_wb", {regWrite_out, memtoReg_out, fault_out}, 32'h0);
      chk("rst_wb_data", ALUResult_out | readData_out | inst_out, 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 15; i++) do_instr(tab[i]);

      do_instr(tab[0]);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_rw", 32'(regWrite_out), 32'h0);
      chk("async_rst_alu", ALUResult_out, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;

      v = mk(1, 0, 1, 1, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 1, 1, 4'b0000, 32'h0, 32'h0, 0);
      memRead_in = 1'b1; memtoReg_in = 1'b1; regWrite_in = 1'b1;
      ALUResult_in = v.addr; inst_in = v.inst;
      @(posedge clk); #1;
      chk("midbusy_req", 32'(bus.mem_req), 32'h1);
      #2 rst = 1'b0;
      #1;
      chk("midbusy_rst_req", 32'(bus.mem_req), 32'h0);
      chk("midbusy_rst_stall", 32'(stall_out), 32'h0);
      chk("midbusy_rst_wb", {regWrite_out, memtoReg_out, fault_out}, 32'h0);
      clear_inputs();
      @(posedge clk); #1;
      rst = 1'b1;
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      chk("late_ack_req", 32'(bus.mem_req), 32'h0);
      chk("late_ack_rd", readData_out, 32'h0);
      chk("late_ack_wb", {regWrite_out, memtoReg_out, fault_out, stall_out}, 32'h0);
      do_instr(tab[2]);

      for (int n = 0; n < 200; n++) begin
         v = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                $urandom, $urandom, $urandom, int'($urandom_range(0, 6)),
                0, 4'h0, 32'h0, 32'h0, 1'b0);
         if ($urandom_range(0, 3) != 0 && !(v.rd | v.wr)) v.rd = 1'b1;
         do_instr(model(v));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the EX/MEM register and feeding the writeback mux. Turns load/store control from EX/MEM into byte-lane-correct transactions on a req/ack data-memory bus, stalls upstream while a transaction is outstanding, and registers the MEM/WB payload (control, ALU result, aligned load data, instruction) itself. Misaligned, illegal or timed-out accesses are suppressed and flagged.

## Interface
- TIMEOUT, 16: max BUSY cycles waiting for mem_ack before abort; 0 disables the timeout.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- memRead_in, memWrite_in, memtoReg_in, regWrite_in  in  1 each  control from EX/MEM
- ALUResult_in  in  32  effective address / ALU result
- rs2_in  in  32  store data
- inst_in  in  32  instruction; funct3 = inst_in[14:12]
- stall_out  out  1  hold EX/MEM and earlier stages this cycle
- mem_req  out  1  bus request; mem_we  out  1  write enable
- mem_addr  out  32  word address {ALUResult[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data; mem_wstrb  out  4  byte strobes
- mem_ack  in  1  one-cycle completion; mem_rdata  in  32  valid when mem_ack=1
- memtoReg_out, regWrite_out  out  1 each  to WB
- ALUResult_out, readData_out, inst_out  out  32 each  to WB
- fault_out  out  1  one-cycle pulse aligned with the faulting instruction's WB outputs

## Operation
- Access = memRead_in | memWrite_in (both high: treat as write). Widths from funct3: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned (loads only).
- Fault: half with addr[0]=1; word with addr[1:0]≠0; illegal funct3 (load 011/110/111, store ≥011); timeout. Fault → no bus transaction (or abort), regWrite_out=0, memtoReg_out=0, fault_out=1.
- Store: mem_wdata = byte replicated ×4 / half replicated ×2 / word; mem_wstrb = 0001<<addr[1:0] (SB), 0011<<addr[1:0] (SH), 1111 (SW).
- Load: shift mem_rdata right 8·addr[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU); LW unchanged. readData_out=0 for non-loads.
- FSM: IDLE, BUSY, RESP.
  - IDLE, no access or fault: stall_out=0; WB outputs capture at edge.
  - IDLE, legal access: stall_out=1 combinationally; next edge → BUSY, mem_req=1, addr/we/wdata/wstrb registered.
  - BUSY: stall_out=1; bus outputs held stable. mem_ack=1 → capture aligned data, mem_req=0, → RESP. Counter reaches TIMEOUT without ack → mem_req=0, latch fault, → RESP.
  - RESP: stall_out=0; WB outputs capture at edge from captured data; → IDLE.
- mem_ack while not BUSY is ignored.

## Timing
- Reset (async assert): state IDLE, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=mem_wdata=0, all WB outputs 0, fault_out=0, timeout counter 0. Reset mid-BUSY abandons the transaction with no writeback.
- Non-memory/faulting instruction: 1-cycle latency, no stall.
- Memory access with ack after k BUSY cycles (k≥1): stall_out high for 1+k cycles; WB outputs valid after the edge ending RESP; total 2+k cycles.
- Upstream keeps inputs stable while stall_out=1; block does not re-sample them in BUSY/RESP.
- Timeout fires at the edge where BUSY count = TIMEOUT with no ack; ack on that same edge wins (normal completion).
- fault_out and regWrite_out are registered; one cycle each per instruction.

## Structure
- Package mem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum {IDLE, BUSY, RESP}.
- Sub-module mem_align (combinational): funct3+addr[1:0]+rs2 → wdata/wstrb/fault; funct3+addr[1:0]+rdata → extended load data. FSM, counter and WB registers stay in mem_stage.

## Test plan
- ALU op, regWrite_in=1, ALUResult_in=0x0000_1234 → no stall; next edge ALUResult_out=0x1234, regWrite_out=1, readData_out=0.
- SB addr 0x103, rs2=0x0000_00A5, ack after 2 BUSY cycles → mem_wstrb=1000, mem_wdata=0xA5A5_A5A5, mem_addr=0x100, stall high 3 cycles.
- LH addr 0x102, mem_rdata=0x8001_7FFF → readData_out=0xFFFF_8001; LHU same → 0x0000_8001.
- LW addr 0x106 → no mem_req, fault_out=1, regWrite_out=0, no stall.
- LW addr 0x200, TIMEOUT=4, mem_ack never → mem_req drops after 4 BUSY cycles, fault_out=1, regWrite_out=0; ack on cycle 4 instead → normal load.
- rst low during BUSY → mem_req=0, stall_out=0, all WB outputs 0 immediately; later ack ignored.
